// File: rtl/sa_stream_mm_engine.sv
// sa_stream_mm_engine: output-stationary SA_R x SA_C signed MAC array, K streamed as X/W beats, rows drained under backpressure
// Ports:
//   I_CLK, I_ASYN_RSTN          clock (rising edge), asynchronous active-low reset
//   I_START_FLAG, I_M_DIM       start pulse, reduction length K (1..MAX_K), I_SHIFT requant shift
//   I_IN_VLD / O_IN_RDY         X column / W row beat handshake, operands on I_X_VEC / I_W_VEC
//   O_OUT_VLD / I_OUT_RDY       result row handshake, row on O_OUT_ROW with index O_OUT_IDX
//   O_BUSY, O_DONE, O_ERR       not idle, end-of-job pulse, rejected-start pulse
// Optional feature: define SA_REQUANT_EN to emit sat_D_W(acc >>> I_SHIFT) instead of raw accumulators.
module sa_stream_mm_engine #(
    parameter  int D_W   = 8,
    parameter  int SA_R  = 16,
    parameter  int SA_C  = 16,
    parameter  int MAX_K = 128,
    localparam int ACC_W = 2 * D_W + $clog2(MAX_K),
    localparam int RW    = $clog2(SA_R)
) (
    input  logic                  I_CLK,
    input  logic                  I_ASYN_RSTN,
    input  logic                  I_START_FLAG,
    input  logic [7:0]            I_M_DIM,
    input  logic [3:0]            I_SHIFT,
    input  logic                  I_IN_VLD,
    output logic                  O_IN_RDY,
    input  logic [SA_R*D_W-1:0]   I_X_VEC,
    input  logic [SA_C*D_W-1:0]   I_W_VEC,
    output logic                  O_OUT_VLD,
    input  logic                  I_OUT_RDY,
    output logic [SA_C*ACC_W-1:0] O_OUT_ROW,
    output logic [RW-1:0]         O_OUT_IDX,
    output logic                  O_BUSY,
    output logic                  O_DONE,
    output logic                  O_ERR
);
    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;
    state_t state_q, state_d;
    logic [7:0] k_q, cnt_q;
    logic [RW-1:0] row_q;
    logic err_q, done_q;
    logic k_ok, start_ok, beat, shift_en, out_hs, load_last, flush_last, drain_last;
    logic signed [D_W-1:0] x_in [SA_R];
    logic signed [D_W-1:0] w_in [SA_C];
    logic signed [D_W-1:0] x_sk [SA_R];
    logic signed [D_W-1:0] w_sk [SA_C];
    logic signed [D_W-1:0] a_d [SA_R][SA_C];
    logic signed [D_W-1:0] b_d [SA_R][SA_C];
    logic signed [D_W-1:0] a_q [SA_R][SA_C];
    logic signed [D_W-1:0] b_q [SA_R][SA_C];
    logic signed [ACC_W-1:0] acc_q [SA_R][SA_C];

    always_comb begin
        k_ok       = I_M_DIM != 8'd0 && int'(I_M_DIM) <= MAX_K;
        start_ok   = state_q == IDLE && I_START_FLAG && k_ok;
        beat       = state_q == LOAD && I_IN_VLD;
        shift_en   = beat || state_q == FLUSH;
        out_hs     = state_q == DRAIN && I_OUT_RDY;
        load_last  = beat && cnt_q == k_q - 8'd1;
        flush_last = state_q == FLUSH && cnt_q == 8'(SA_R + SA_C - 2);
        drain_last = out_hs && row_q == RW'(SA_R - 1);
        state_d    = start_ok ? LOAD : load_last ? FLUSH : flush_last ? DRAIN : drain_last ? IDLE : state_q;
    end

    always_ff @(posedge I_CLK or negedge I_ASYN_RSTN)
        if (!I_ASYN_RSTN) state_q <= IDLE;
        else state_q <= state_d;

    // cnt_q counts accepted beats in LOAD, then flush cycles in FLUSH
    always_ff @(posedge I_CLK or negedge I_ASYN_RSTN)
        if (!I_ASYN_RSTN) begin
            k_q    <= '0;
            cnt_q  <= '0;
            row_q  <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            err_q  <= state_q == IDLE && I_START_FLAG && !k_ok;
            done_q <= drain_last;
            k_q    <= start_ok ? I_M_DIM : k_q;
            cnt_q  <= (start_ok || load_last || flush_last) ? '0 : shift_en ? cnt_q + 8'd1 : cnt_q;
            row_q  <= start_ok ? '0 : out_hs ? row_q + RW'(1) : row_q;
        end

    always_comb begin
        for (int i = 0; i < SA_R; i++) x_in[i] = beat ? I_X_VEC[i*D_W +: D_W] : '0;
        for (int i = 0; i < SA_C; i++) w_in[i] = beat ? I_W_VEC[i*D_W +: D_W] : '0;
    end

    // Input skew: X row r and W column c see r and c extra delay stages so that
    // matching k operands meet in PE(r,c) after k+r+c shifts.
    for (genvar r = 0; r < SA_R; r++) begin : g_xsk
        if (r == 0) begin : g_pass
            assign x_sk[r] = x_in[r];
        end else begin : g_dly
            logic signed [D_W-1:0] d_q [r];
            always_ff @(posedge I_CLK or negedge I_ASYN_RSTN)
                if (!I_ASYN_RSTN) begin
                    for (int i = 0; i < r; i++) d_q[i] <= '0;
                end else if (start_ok || shift_en) begin
                    d_q[0] <= start_ok ? '0 : x_in[r];
                    for (int i = 1; i < r; i++) d_q[i] <= start_ok ? '0 : d_q[i-1];
                end
            assign x_sk[r] = d_q[r-1];
        end
    end

    for (genvar c = 0; c < SA_C; c++) begin : g_wsk
        if (c == 0) begin : g_pass
            assign w_sk[c] = w_in[c];
        end else begin : g_dly
            logic signed [D_W-1:0] d_q [c];
            always_ff @(posedge I_CLK or negedge I_ASYN_RSTN)
                if (!I_ASYN_RSTN) begin
                    for (int i = 0; i < c; i++) d_q[i] <= '0;
                end else if (start_ok || shift_en) begin
                    d_q[0] <= start_ok ? '0 : w_in[c];
                    for (int i = 1; i < c; i++) d_q[i] <= start_ok ? '0 : d_q[i-1];
                end
            assign w_sk[c] = d_q[c-1];
        end
    end

    // X travels right along rows, W travels down columns
    for (genvar r = 0; r < SA_R; r++) begin : g_row
        for (genvar c = 0; c < SA_C; c++) begin : g_col
            if (c == 0) begin : g_xl
                assign a_d[r][c] = x_sk[r];
            end else begin : g_xp
                assign a_d[r][c] = a_q[r][c-1];
            end
            if (r == 0) begin : g_wt
                assign b_d[r][c] = w_sk[c];
            end else begin : g_wp
                assign b_d[r][c] = b_q[r-1][c];
            end
        end
    end

    always_ff @(posedge I_CLK or negedge I_ASYN_RSTN)
        if (!I_ASYN_RSTN) begin
            for (int i = 0; i < SA_R; i++)
                for (int j = 0; j < SA_C; j++) begin
                    a_q[i][j]   <= '0;
                    b_q[i][j]   <= '0;
                    acc_q[i][j] <= '0;
                end
        end else if (start_ok || shift_en) begin
            for (int i = 0; i < SA_R; i++)
                for (int j = 0; j < SA_C; j++) begin
                    a_q[i][j]   <= start_ok ? '0 : a_d[i][j];
                    b_q[i][j]   <= start_ok ? '0 : b_d[i][j];
                    acc_q[i][j] <= start_ok ? '0 : acc_q[i][j] + ACC_W'(a_q[i][j]) * ACC_W'(b_q[i][j]);
                end
        end

`ifdef SA_REQUANT_EN
    localparam logic signed [ACC_W-1:0] sat_hi = ACC_W'((1 << (D_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] sat_lo = ACC_W'(-(1 << (D_W - 1)));
    logic [3:0] shift_q;
    logic signed [ACC_W-1:0] rq;

    always_ff @(posedge I_CLK or negedge I_ASYN_RSTN)
        if (!I_ASYN_RSTN) shift_q <= '0;
        else shift_q <= start_ok ? I_SHIFT : shift_q;

    always_comb begin
        O_OUT_ROW = '0;
        rq        = '0;
        for (int j = 0; j < SA_C; j++) begin
            rq = acc_q[row_q][j] >>> shift_q;
            O_OUT_ROW[j*ACC_W +: ACC_W] = rq > sat_hi ? sat_hi : rq < sat_lo ? sat_lo : rq;
        end
    end
`else
    logic unused_shift;
    assign unused_shift = ^I_SHIFT;

    always_comb begin
        O_OUT_ROW = '0;
        for (int j = 0; j < SA_C; j++) O_OUT_ROW[j*ACC_W +: ACC_W] = acc_q[row_q][j];
    end
`endif

    assign O_IN_RDY  = state_q == LOAD;
    assign O_OUT_VLD = state_q == DRAIN;
    assign O_OUT_IDX = row_q;
    assign O_BUSY    = state_q != IDLE;
    assign O_DONE    = done_q;
    assign O_ERR     = err_q;
endmodule

// File: tb/tb_sa_stream_mm_engine.sv
// tb_sa_stream_mm_engine: directed table-driven bench for sa_stream_mm_engine
module tb_sa_stream_mm_engine;
    localparam int D_W   = 8;
    localparam int SA_R  = 16;
    localparam int SA_C  = 16;
    localparam int MAX_K = 128;
    localparam int ACC_W = 2 * D_W + $clog2(MAX_K);
    localparam int RW    = $clog2(SA_R);

    logic                  I_CLK = 1'b0;
    logic                  I_ASYN_RSTN;
    logic                  I_START_FLAG;
    logic [7:0]            I_M_DIM;
    logic [3:0]            I_SHIFT;
    logic                  I_IN_VLD;
    logic                  O_IN_RDY;
    logic [SA_R*D_W-1:0]   I_X_VEC;
    logic [SA_C*D_W-1:0]   I_W_VEC;
    logic                  O_OUT_VLD;
    logic                  I_OUT_RDY;
    logic [SA_C*ACC_W-1:0] O_OUT_ROW;
    logic [RW-1:0]         O_OUT_IDX;
    logic                  O_BUSY;
    logic                  O_DONE;
    logic                  O_ERR;

    int checks = 0;
    int failures = 0;

    always #5 I_CLK = ~I_CLK;

    sa_stream_mm_engine #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C), .MAX_K(MAX_K)) dut (
        .I_CLK(I_CLK), .I_ASYN_RSTN(I_ASYN_RSTN), .I_START_FLAG(I_START_FLAG),
        .I_M_DIM(I_M_DIM), .I_SHIFT(I_SHIFT), .I_IN_VLD(I_IN_VLD), .O_IN_RDY(O_IN_RDY),
        .I_X_VEC(I_X_VEC), .I_W_VEC(I_W_VEC), .O_OUT_VLD(O_OUT_VLD), .I_OUT_RDY(I_OUT_RDY),
        .O_OUT_ROW(O_OUT_ROW), .O_OUT_IDX(O_OUT_IDX), .O_BUSY(O_BUSY), .O_DONE(O_DONE), .O_ERR(O_ERR)
    );

    typedef struct {
        int     k;
        int     xv;
        int     wv;
        bit     ramp;
        bit     bubble;
        int     shift;
        int     stall_row;
        bit     poke;
        int     abort_at;
        longint exp_raw;
        longint exp_rq;
    } vec_t;

    vec_t tv [12];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic err_start(input int k);
        I_START_FLAG = 1'b1;
        I_M_DIM      = 8'(k);
        @(posedge I_CLK); #1;
        I_START_FLAG = 1'b0;
        chk("err_pulse", O_ERR, 1);
        chk("err_busy", O_BUSY, 0);
        @(posedge I_CLK); #1;
        chk("err_clear", O_ERR, 0);
        chk("err_busy_after", O_BUSY, 0);
    endtask

    task automatic run_job(input vec_t v);
        int cyc, beat, row, stall;
        bit seen, acc, hs, st;
        longint exp, act;
        logic signed [ACC_W-1:0] e;
`ifdef SA_REQUANT_EN
        exp = v.exp_rq;
`else
        exp = v.exp_raw;
`endif
        I_START_FLAG = 1'b1;
        I_M_DIM      = 8'(v.k);
        I_SHIFT      = 4'(v.shift);
        @(posedge I_CLK); #1;
        I_START_FLAG = 1'b0;
        chk("busy_after_start", O_BUSY, 1);
        cyc = 1; beat = 0; row = 0; stall = 0; seen = 1'b0;
        while (row < SA_R && cyc < 2000) begin
            if (v.abort_at != 0 && cyc == v.abort_at) begin
                I_ASYN_RSTN = 1'b0;
                #1;
                chk("abort_busy", O_BUSY, 0);
                chk("abort_in_rdy", O_IN_RDY, 0);
                chk("abort_out_vld", O_OUT_VLD, 0);
                @(posedge I_CLK); #1;
                chk("abort_no_done", O_DONE, 0);
                I_ASYN_RSTN = 1'b1;
                I_IN_VLD    = 1'b0;
                return;
            end
            if (O_OUT_VLD) begin
                if (!seen && !v.bubble) chk("first_vld_latency", cyc, v.k + SA_R + SA_C);
                seen = 1'b1;
                chk("out_idx", O_OUT_IDX, row);
                act = exp;
                for (int c = 0; c < SA_C; c++) begin
                    e = O_OUT_ROW[c*ACC_W +: ACC_W];
                    if (e != exp && act == exp) act = e;
                end
                chk("row_data", act, exp);
            end
            if (v.poke && cyc == 6) begin
                chk("ignored_start_err", O_ERR, 0);
                chk("ignored_start_in_rdy", O_IN_RDY, 1);
            end
            I_START_FLAG = v.poke && cyc == 5;
            if (v.poke && cyc == 5) I_M_DIM = 8'd3;
            I_IN_VLD = beat < v.k && (!v.bubble || cyc % 2 == 1);
            for (int r = 0; r < SA_R; r++) I_X_VEC[r*D_W +: D_W] = 8'(v.ramp ? beat : v.xv);
            for (int c = 0; c < SA_C; c++) I_W_VEC[c*D_W +: D_W] = 8'(v.ramp ? beat : v.wv);
            I_OUT_RDY = !(row == v.stall_row && stall < 5);
            acc = I_IN_VLD && O_IN_RDY;
            hs  = O_OUT_VLD && I_OUT_RDY;
            st  = O_OUT_VLD && !I_OUT_RDY;
            @(posedge I_CLK); #1;
            if (acc) beat++;
            if (hs) row++;
            if (st) stall++;
            cyc++;
        end
        I_IN_VLD     = 1'b0;
        I_START_FLAG = 1'b0;
        chk("rows_received", row, SA_R);
        chk("beats_accepted", beat, v.k);
        if (v.stall_row >= 0) chk("stall_cycles", stall, 5);
        chk("done_pulse", O_DONE, 1);
        chk("idle_busy", O_BUSY, 0);
        chk("idle_out_vld", O_OUT_VLD, 0);
        @(posedge I_CLK); #1;
        chk("done_clear", O_DONE, 0);
    endtask

    initial begin
        //          k    xv    wv   ramp  bub   sh  stall poke  abort  raw       rq
        tv[0]  = '{16,   1,    2,   1'b0, 1'b0, 0,  -1,   1'b0, 0,     32,       32};
        tv[1]  = '{16,   0,    0,   1'b1, 1'b0, 0,  -1,   1'b0, 0,     1240,     127};
        tv[2]  = '{16,   0,    0,   1'b1, 1'b1, 0,  -1,   1'b0, 0,     1240,     127};
        tv[3]  = '{16,   1,    2,   1'b0, 1'b0, 0,  3,    1'b0, 0,     32,       32};
        tv[4]  = '{16,   1,    2,   1'b0, 1'b0, 0,  -1,   1'b1, 0,     32,       32};
        tv[5]  = '{16,   1,    2,   1'b0, 1'b0, 0,  -1,   1'b0, 25,    0,        0};
        tv[6]  = '{1,    3,    -2,  1'b0, 1'b0, 0,  -1,   1'b0, 0,     -6,       -6};
        tv[7]  = '{128,  -128, -128, 1'b0, 1'b0, 0, -1,   1'b0, 0,     2097152,  127};
        tv[8]  = '{128,  -128, 127, 1'b0, 1'b0, 0,  -1,   1'b0, 0,     -2080768, -128};
        tv[9]  = '{16,   127,  127, 1'b0, 1'b0, 0,  -1,   1'b0, 0,     258064,   127};
        tv[10] = '{16,   -128, 127, 1'b0, 1'b0, 0,  -1,   1'b0, 0,     -260096,  -128};
        tv[11] = '{16,   1,    2,   1'b0, 1'b0, 2,  -1,   1'b0, 0,     32,       8};

        I_ASYN_RSTN  = 1'b0;
        I_START_FLAG = 1'b0;
        I_M_DIM      = '0;
        I_SHIFT      = '0;
        I_IN_VLD     = 1'b0;
        I_X_VEC      = '0;
        I_W_VEC      = '0;
        I_OUT_RDY    = 1'b0;
        repeat (3) @(posedge I_CLK);
        #1;
        chk("rst_busy", O_BUSY, 0);
        chk("rst_in_rdy", O_IN_RDY, 0);
        chk("rst_out_vld", O_OUT_VLD, 0);
        chk("rst_done", O_DONE, 0);
        chk("rst_err", O_ERR, 0);
        chk("rst_row_zero", (O_OUT_ROW == '0) ? 1 : 0, 1);
        I_ASYN_RSTN = 1'b1;
        @(posedge I_CLK); #1;

        err_start(0);
        err_start(200);
        err_start(MAX_K + 1);

        for (int i = 0; i < 12; i++) run_job(tv[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
